systolic_mm_engine: RTL and testbench
=====================================

// Module: systolic_mm_engine
// PURPOSE
//  Parametrised N x N output-stationary systolic matrix-multiply engine; computes C = A*B (signed) for self-attention.
//  Streams one K-slice per beat (column k of A, row k of B), skews operands internally and accumulates in the PE grid.
//  Drains C one row per beat over a valid/ready port; successor of the fixed 4x4 array with handshakes and saturation.
// PARAMETERS
//  N      4   array dimension (rows of A = cols of B = N), N >= 2
//  DW     8   operand width, signed two's complement
//  ACC_W  18  accumulator/result width, signed; >= 2*DW
//  SAT    0   0: accumulators wrap modulo 2^ACC_W; 1: saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1]
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        synchronous, active-high
//  start      in   1        pulse: clear accumulators, begin new job (honoured in IDLE only)
//  in_valid   in   1        slice beat valid
//  in_ready   out  1        engine accepts slice beat
//  in_last    in   1        marks final K-slice of job
//  a_col      in   N*DW     A[i][k] at bits [i*DW +: DW]
//  b_row      in   N*DW     B[k][j] at bits [j*DW +: DW]
//  out_valid  out  1        result row valid
//  out_ready  in   1        downstream accepts result row
//  out_last   out  1        high with row N-1
//  out_row    out  N*ACC_W  C[r][j] at bits [j*ACC_W +: ACC_W]
//  busy       out  1        high in every state except IDLE
//  done       out  1        one-cycle pulse after last row handshake
// BEHAVIOUR
//  Reset: state IDLE; all accumulators, skew regs, counters zero; in_ready=0, out_valid=0, out_last=0, out_row=0, busy=0, done=0.
//  Reset mid-job aborts everything immediately; no partial output afterwards.
//  FSM: IDLE -start-> LOAD; LOAD -(in_valid&in_ready&in_last)-> FLUSH; FLUSH -(2N-1 cycles)-> DRAIN;
//   DRAIN -(out_valid&out_ready&row==N-1)-> IDLE, done=1 in the following cycle.
//  start in IDLE: accumulators cleared the same edge; in_ready=1 from next cycle. start outside IDLE ignored.
//  in_ready = 1 only in LOAD; beat accepted on in_valid&in_ready. Cycles with no accepted beat inject zeros (bubble).
//  Skew: row i of A delayed i cycles, col j of B delayed j cycles; A passes right, B passes down, 1 reg per PE.
//  Slice accepted at cycle t updates PE(i,j) at edge t+i+j+1; last update at T+2N-1 for last beat at T -> FLUSH = 2N-1 cycles.
//  MAC: acc <= acc + sext(a*b); product 2*DW signed, sign-extended to ACC_W; SAT=1 clamps on overflow, sticky at limit.
//  K (number of slices) unbounded; K=1 allowed (in_last on first beat).
//  DRAIN: out_row = row r of C, r from 0; r advances on out_valid&out_ready; out_row/out_valid stable while out_ready=0.
//  out_last = out_valid & (r==N-1). No new slice accepted until IDLE -> start.
//  Latency: last in beat -> first out_valid = 2N cycles (FLUSH 2N-1 + 1).
// TESTING
//  1. N=4: A=I, B[k][j]=4k+j, K=4, out_ready=1 -> rows = B rows; out_valid 8 cycles after last beat; done 1 cycle after row 3.
//  2. A,B all -128, K=4, SAT=0 -> every C = 65536; K=8 -> wrap to -131072 (0x20000 in 18b).
//  3. Same K=8 with SAT=1 -> every C = 131071; all -128 x +127 K=8 -> every C = -130048 (no clamp).
//  4. Random A,B (seeded), in_valid 50% bubbles, out_ready toggling -> C matches reference model; out_row stable when stalled.
//  5. reset asserted mid-FLUSH and mid-DRAIN -> next cycle busy=0, out_valid=0; following job from start yields correct C.
//  6. start pulses during LOAD/DRAIN -> ignored, results unaffected; K=1 job (in_last on first beat) -> C = outer product.

Source files
------------

// File: rtl/systolic_mm_if.sv
// Stream interface of the systolic matrix-multiply engine: slice beats in, result rows out.
// The master side drives jobs and slices; the slave side is the engine.
interface systolic_mm_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned ACC_W = 18
);
  logic               start;
  logic               in_valid;
  logic               in_ready;
  logic               in_last;
  logic [N*DW-1:0]    a_col;
  logic [N*DW-1:0]    b_row;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic [N*ACC_W-1:0] out_row;
  logic               busy;
  logic               done;

  modport master (
    output start, in_valid, in_last, a_col, b_row, out_ready,
    input  in_ready, out_valid, out_last, out_row, busy, done
  );

  modport slave (
    input  start, in_valid, in_last, a_col, b_row, out_ready,
    output in_ready, out_valid, out_last, out_row, busy, done
  );
endinterface

// File: rtl/systolic_mm_engine.sv
// N x N output-stationary systolic engine computing C = A*B from streamed K-slices.
// Operands are skewed on entry, flow right (A) and down (B); C drains one row per handshake.
module systolic_mm_engine #(
  parameter int unsigned N     = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned ACC_W = 18,
  parameter bit          SAT   = 1'b0
) (
  input logic          clk,
  input logic          reset,
  systolic_mm_if.slave bus
);
  localparam int unsigned RW = (N > 2) ? $clog2(N) : 1;
  localparam int unsigned FW = $clog2(2 * N);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDrain} state_e;

  state_e            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [FW-1:0]     flush_q, flush_d;
  logic              in_ready_q, out_valid_q, out_last_q, busy_q, done_q, done_d;
  logic              start_go, beat_go, out_go, acc_en;

  logic signed [DW-1:0]    a_edge [N];
  logic signed [DW-1:0]    b_edge [N];
  logic signed [DW-1:0]    a_op   [N][N];
  logic signed [DW-1:0]    b_op   [N][N];
  logic signed [DW-1:0]    a_pe_q [N][N-1];
  logic signed [DW-1:0]    b_pe_q [N-1][N];
  logic signed [ACC_W-1:0] acc_q  [N][N];
  logic signed [ACC_W-1:0] acc_d  [N][N];
  logic [N*ACC_W-1:0]      out_row_c;

  assign start_go = bus.start && (state_q == StIdle);
  assign beat_go  = bus.in_valid && in_ready_q;
  assign out_go   = out_valid_q && bus.out_ready;
  assign acc_en   = (state_q == StLoad) || (state_q == StFlush);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    flush_d = flush_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_go) begin
          state_d = StLoad;
          row_d   = '0;
        end
      end
      StLoad: begin
        if (beat_go && bus.in_last) begin
          state_d = StFlush;
          flush_d = '0;
        end
      end
      // Holds until the last slice has reached the far corner PE.
      StFlush: begin
        if (flush_q == FW'(2 * N - 2)) state_d = StDrain;
        else                          flush_d = flush_q + 1'b1;
      end
      StDrain: begin
        if (out_go) begin
          if (row_q == RW'(N - 1)) begin
            state_d = StIdle;
            row_d   = '0;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      row_q       <= '0;
      flush_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      flush_q     <= flush_d;
      in_ready_q  <= (state_d == StLoad);
      out_valid_q <= (state_d == StDrain);
      out_last_q  <= (state_d == StDrain) && (row_d == RW'(N - 1));
      busy_q      <= (state_d != StIdle);
      done_q      <= done_d;
    end
  end

  // Row/column i enters through i+1 stages; bubbles inject zeros.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic signed [DW-1:0] a_sk_q [i+1];
    logic signed [DW-1:0] a_sk_d [i+1];
    logic signed [DW-1:0] b_sk_q [i+1];
    logic signed [DW-1:0] b_sk_d [i+1];

    always_comb begin
      a_sk_d[0] = beat_go ? $signed(bus.a_col[i*DW +: DW]) : '0;
      b_sk_d[0] = beat_go ? $signed(bus.b_row[i*DW +: DW]) : '0;
      for (int s = 1; s <= i; s++) begin
        a_sk_d[s] = a_sk_q[s-1];
        b_sk_d[s] = b_sk_q[s-1];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        a_sk_q <= '{default: '0};
        b_sk_q <= '{default: '0};
      end else begin
        a_sk_q <= a_sk_d;
        b_sk_q <= b_sk_d;
      end
    end

    assign a_edge[i] = a_sk_q[i];
    assign b_edge[i] = b_sk_q[i];
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (j == 0) begin : g_a_edge
        assign a_op[i][j] = a_edge[i];
      end else begin : g_a_pass
        assign a_op[i][j] = a_pe_q[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_op[i][j] = b_edge[j];
      end else begin : g_b_pass
        assign b_op[i][j] = b_pe_q[i-1][j];
      end
    end
  end

  function automatic logic signed [ACC_W-1:0] mac(input logic signed [ACC_W-1:0] acc,
                                                  input logic signed [DW-1:0]    a,
                                                  input logic signed [DW-1:0]    b);
    logic signed [2*DW-1:0] prod;
    logic signed [ACC_W:0]  sum;
    prod = a * b;
    sum  = $signed({acc[ACC_W-1], acc}) + $signed({{(ACC_W + 1 - 2 * DW){prod[2*DW-1]}}, prod});
    if (SAT && (sum[ACC_W] != sum[ACC_W-1])) begin
      return sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
    end
    return sum[ACC_W-1:0];
  endfunction

  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (start_go)    acc_d[i][j] = '0;
        else if (acc_en) acc_d[i][j] = mac(acc_q[i][j], a_op[i][j], b_op[i][j]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '{default: '0};
      a_pe_q <= '{default: '0};
      b_pe_q <= '{default: '0};
    end else begin
      acc_q <= acc_d;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N - 1; j++) begin
          a_pe_q[i][j] <= a_op[i][j];
          b_pe_q[j][i] <= b_op[j][i];
        end
      end
    end
  end

  always_comb begin
    out_row_c = '0;
    for (int j = 0; j < N; j++) begin
      if (out_valid_q) out_row_c[j*ACC_W +: ACC_W] = acc_q[row_q][j];
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_row   = out_row_c;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_systolic_mm_engine.sv
// Bench for systolic_mm_engine: a wrapping and a saturating instance run the same jobs in lockstep
// and are compared against a plain matrix-product reference computed in the bench.
module tb_systolic_mm_engine;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 18;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic            out_ready = 1'b0;
  logic [N*DW-1:0] a_col = '0;
  logic [N*DW-1:0] b_row = '0;

  int tests = 0;
  int fails = 0;

  int ka [64][N];
  int kb [64][N];
  logic signed [AW-1:0] c_w [N][N];
  logic signed [AW-1:0] c_s [N][N];

  typedef struct {
    string name;
    int    pat;    // 0 identity x ramp, 1 all -128, 2 -128 x 127, 3 random
    int    k;
    int    bub;    // bubble percentage on in_valid
    bit    tog;    // random out_ready
    bit    inj;    // stray start pulses while busy
    bit    cst;    // expected C is a single constant
    int    exp_w;
    int    exp_s;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  systolic_mm_if #(.N(N), .DW(DW), .ACC_W(AW)) w_if ();
  systolic_mm_if #(.N(N), .DW(DW), .ACC_W(AW)) s_if ();

  assign w_if.start = start;     assign s_if.start = start;
  assign w_if.in_valid = in_valid; assign s_if.in_valid = in_valid;
  assign w_if.in_last = in_last; assign s_if.in_last = in_last;
  assign w_if.a_col = a_col;     assign s_if.a_col = a_col;
  assign w_if.b_row = b_row;     assign s_if.b_row = b_row;
  assign w_if.out_ready = out_ready; assign s_if.out_ready = out_ready;

  systolic_mm_engine #(.N(N), .DW(DW), .ACC_W(AW), .SAT(1'b0)) u_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (w_if.slave)
  );

  systolic_mm_engine #(.N(N), .DW(DW), .ACC_W(AW), .SAT(1'b1)) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (s_if.slave)
  );

  task automatic chk_b(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, want %b", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_v(input string nm, input logic [N*AW-1:0] act, input logic [N*AW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic chk2(input string nm, input logic aw, input logic as, input logic exp);
    chk_b({nm, " wrap"}, aw, exp);
    chk_b({nm, " sat"}, as, exp);
  endtask

  function automatic logic [N*AW-1:0] pack_row(input bit sat, input int r);
    logic [N*AW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j*AW +: AW] = sat ? c_s[r][j] : c_w[r][j];
    return v;
  endfunction

  task automatic gen(input int pat, input int k_n);
    for (int k = 0; k < k_n; k++) begin
      for (int n = 0; n < N; n++) begin
        case (pat)
          0: begin ka[k][n] = (n == k) ? 1 : 0; kb[k][n] = 4 * k + n; end
          1: begin ka[k][n] = -128; kb[k][n] = -128; end
          2: begin ka[k][n] = -128; kb[k][n] = 127; end
          default: begin
            ka[k][n] = int'($urandom_range(255)) - 128;
            kb[k][n] = int'($urandom_range(255)) - 128;
          end
        endcase
      end
    end
  endtask

  // C[i][j] = sum_k A[i][k]*B[k][j]; the saturating copy clamps after every slice.
  task automatic compute_ref(input int k_n);
    longint hi, lo, sw, ss, p;
    hi = (longint'(1) <<< (AW - 1)) - 1;
    lo = -(longint'(1) <<< (AW - 1));
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        sw = 0;
        ss = 0;
        for (int k = 0; k < k_n; k++) begin
          p  = longint'(ka[k][i]) * longint'(kb[k][j]);
          sw = sw + p;
          ss = ss + p;
          if (ss > hi) ss = hi;
          else if (ss < lo) ss = lo;
        end
        c_w[i][j] = AW'(sw);
        c_s[i][j] = AW'(ss);
      end
    end
  endtask

  task automatic feed(input int k_n, input int bub, input bit inj);
    int k;
    int guard;
    bit v;
    k = 0;
    guard = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (k < k_n && guard < 2000) begin
      chk2($sformatf("in_ready beat%0d", k), w_if.in_ready, s_if.in_ready, 1'b1);
      v = ($urandom_range(99) >= bub);
      in_valid = v;
      in_last  = (k == k_n - 1);
      for (int n = 0; n < N; n++) begin
        a_col[n*DW +: DW] = v ? DW'(ka[k][n]) : DW'($urandom);
        b_row[n*DW +: DW] = v ? DW'(kb[k][n]) : DW'($urandom);
      end
      start = inj & ($urandom_range(1) == 1);
      @(negedge clk);
      if (v) k++;
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    chk2("in_ready after last", w_if.in_ready, s_if.in_ready, 1'b0);
    chk2("busy in flush", w_if.busy, s_if.busy, 1'b1);
    while (!(w_if.out_valid || s_if.out_valid) && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk_i("latency", lat, 2 * N);
  endtask

  task automatic drain(input string nm, input bit tog, input bit inj);
    int  r;
    int  guard;
    bit  rdy;
    r = 0;
    guard = 0;
    while (r < N && guard < 200) begin
      chk2($sformatf("%s out_valid r%0d", nm, r), w_if.out_valid, s_if.out_valid, 1'b1);
      chk2($sformatf("%s out_last r%0d", nm, r), w_if.out_last, s_if.out_last, r == N - 1);
      chk_v($sformatf("%s row%0d wrap", nm, r), w_if.out_row, pack_row(1'b0, r));
      chk_v($sformatf("%s row%0d sat", nm, r), s_if.out_row, pack_row(1'b1, r));
      chk2($sformatf("%s done low r%0d", nm, r), w_if.done, s_if.done, 1'b0);
      rdy = tog ? ($urandom_range(1) == 1) : 1'b1;
      out_ready = rdy;
      start = inj & ($urandom_range(1) == 1);
      @(negedge clk);
      guard++;
      if (rdy) r++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    chk2({nm, " done pulse"}, w_if.done, s_if.done, 1'b1);
    chk2({nm, " busy after"}, w_if.busy, s_if.busy, 1'b0);
    chk2({nm, " valid after"}, w_if.out_valid, s_if.out_valid, 1'b0);
    @(negedge clk);
    chk2({nm, " done one cycle"}, w_if.done, s_if.done, 1'b0);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    gen(v.pat, v.k);
    compute_ref(v.k);
    if (v.cst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          c_w[i][j] = AW'(v.exp_w);
          c_s[i][j] = AW'(v.exp_s);
        end
      end
    end
    feed(v.k, v.bub, v.inj);
    wait_out(lat);
    if (w_if.out_valid || s_if.out_valid) drain(v.name, v.tog, v.inj);
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_mid(input bit in_drain);
    int lat;
    bit saw;
    string nm;
    nm = in_drain ? "rst drain" : "rst flush";
    gen(3, 3);
    feed(3, 0, 1'b0);
    if (!in_drain) begin
      repeat (2) @(negedge clk);
    end else begin
      wait_out(lat);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    chk2({nm, " busy"}, w_if.busy, s_if.busy, 1'b0);
    chk2({nm, " out_valid"}, w_if.out_valid, s_if.out_valid, 1'b0);
    chk2({nm, " in_ready"}, w_if.in_ready, s_if.in_ready, 1'b0);
    chk_v({nm, " out_row"}, w_if.out_row | s_if.out_row, '0);
    reset = 1'b0;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (w_if.out_valid || s_if.out_valid || w_if.busy || s_if.busy) saw = 1'b1;
    end
    chk_b({nm, " quiet afterwards"}, saw, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{"ident",    0, 4,  0,  1'b0, 1'b0, 1'b0, 0, 0};
    vecs[1] = '{"neg k4",   1, 4,  0,  1'b0, 1'b0, 1'b1, 65536, 65536};
    vecs[2] = '{"neg k8",   1, 8,  0,  1'b0, 1'b0, 1'b1, -131072, 131071};
    vecs[3] = '{"negpos k8", 2, 8, 0,  1'b0, 1'b0, 1'b1, -130048, -130048};
    vecs[4] = '{"rand k6",  3, 6,  50, 1'b1, 1'b0, 1'b0, 0, 0};
    vecs[5] = '{"rand k9",  3, 9,  50, 1'b1, 1'b1, 1'b0, 0, 0};
    vecs[6] = '{"outer k1", 3, 1,  0,  1'b1, 1'b1, 1'b0, 0, 0};
    vecs[7] = '{"rand k16", 3, 16, 30, 1'b1, 1'b0, 1'b0, 0, 0};

    repeat (3) @(negedge clk);
    chk2("reset in_ready", w_if.in_ready, s_if.in_ready, 1'b0);
    chk2("reset out_valid", w_if.out_valid, s_if.out_valid, 1'b0);
    chk2("reset out_last", w_if.out_last, s_if.out_last, 1'b0);
    chk2("reset busy", w_if.busy, s_if.busy, 1'b0);
    chk2("reset done", w_if.done, s_if.done, 1'b0);
    chk_v("reset out_row", w_if.out_row | s_if.out_row, '0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 8; t++) run_vec(vecs[t]);

    reset_mid(1'b0);
    run_vec(vecs[4]);
    reset_mid(1'b1);
    run_vec(vecs[5]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
